mem_access_stage: RTL and testbench

Memory-access stage placed directly downstream of the execute stage in the nexus-v core. It takes the execute stage's ALU result as the effective address, and the rs2 operand as store data, for RISC-V load/store instructions. It runs a request/grant/response transaction on the data-memory port and returns a sign/zero-extended load result, or a store completion, to writeback. While an access is in flight it holds off the core through a ready/valid handshake.

---
 rtl/nexus_mem_pkg.sv | 54 +++++
 rtl/mem_access_stage_if.sv | 17 +
 rtl/mem_load_align.sv | 26 ++
 rtl/mem_access_stage.sv | 156 +++++++++++++++
 tb/tb_mem_access_stage.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nexus_mem_pkg.sv
// rtl/nexus_mem_pkg.sv - funct3 codes, FSM states and lane helpers for the memory-access stage
`ifndef WIDTH
`define WIDTH 32
`endif

package nexus_mem_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        ERR,
        DRAIN
    } state_t;

    // Byte enables for an access; loads and stores share the same lane rule.
    function automatic logic [3:0] be_for(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (funct3)
            LB, LBU: be = 4'b0001 << addr_lo;
            LH, LHU: be = 4'b0011 << {addr_lo[1], 1'b0};
            LW:      be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // True when the access must be answered with an error instead of a request.
    function automatic logic access_fault(input logic is_store, input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
        logic illegal;
        logic misaligned;
        if (is_store) begin
            illegal = (funct3 >= 3'b011);
        end else begin
            illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        end
        misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
        return illegal | misaligned;
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - data-memory request/grant/response port
interface mem_access_stage_if;
    import nexus_mem_pkg::*;

    logic            req;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata;
    logic            gnt;
    logic            rvalid;
    logic [XLEN-1:0] rdata;

    modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - lane shift and sign/zero extension of a read word
module mem_load_align
    import nexus_mem_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);

    logic [XLEN-1:0] shifted;

    // Bring the addressed byte/halfword down to lane 0, then extend.
    always_comb begin
        shifted = rdata >> {addr_lo, 3'b000};
        case (funct3)
            LB:      data = {{24{shifted[7]}}, shifted[7:0]};
            LH:      data = {{16{shifted[15]}}, shifted[15:0]};
            LW:      data = shifted;
            LBU:     data = {24'b0, shifted[7:0]};
            LHU:     data = {16'b0, shifted[15:0]};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - RV32 load/store memory-access stage (optional NEXUS_MEM_TIMEOUT_EN timeout)
module mem_access_stage
    import nexus_mem_pkg::*;
#(
    parameter int WIDTH          = `WIDTH,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                is_store,
    input  logic [2:0]          funct3,
    input  logic [WIDTH-1:0]    addr,
    input  logic [WIDTH-1:0]    store_data,
    mem_access_stage_if.master  dmem,
    output logic                out_valid,
    output logic [WIDTH-1:0]    load_data,
    output logic                mem_err
);

    state_t           state;
    logic             r_store;
    logic [2:0]       r_funct3;
    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] r_sdata;
    logic [WIDTH-1:0] align_data;
    logic [WIDTH-1:0] fmt_wdata;
    logic             req_active;

`ifdef NEXUS_MEM_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tmo_cnt;
    logic        tmo_hit;
    assign tmo_hit = (tmo_cnt >= TMO_LAST);
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = (TIMEOUT_CYCLES == 0);
`endif

    mem_load_align u_align (
        .rdata   (dmem.rdata),
        .addr_lo (r_addr[1:0]),
        .funct3  (r_funct3),
        .data    (align_data)
    );

    // Replicate store data across the lanes selected by the byte enables.
    always_comb begin
        case (r_funct3)
            SB:      fmt_wdata = {4{r_sdata[7:0]}};
            SH:      fmt_wdata = {2{r_sdata[15:0]}};
            SW:      fmt_wdata = r_sdata;
            default: fmt_wdata = '0;
        endcase
    end

    // Bus outputs are decoded from state so reset drops the request immediately.
    assign req_active = (state == REQ);
    assign in_ready   = (state == IDLE);
    assign dmem.req   = req_active;
    assign dmem.we    = req_active & r_store;
    assign dmem.addr  = req_active ? {r_addr[WIDTH-1:2], 2'b00} : '0;
    assign dmem.be    = req_active ? be_for(r_funct3, r_addr[1:0]) : 4'b0000;
    assign dmem.wdata = (req_active && r_store) ? fmt_wdata : '0;

    // Transaction FSM with capture registers and registered completion outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            r_store   <= 1'b0;
            r_funct3  <= '0;
            r_addr    <= '0;
            r_sdata   <= '0;
            out_valid <= 1'b0;
            load_data <= '0;
            mem_err   <= 1'b0;
`ifdef NEXUS_MEM_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
        end else begin
            out_valid <= 1'b0;
            mem_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        r_store  <= is_store;
                        r_funct3 <= funct3;
                        r_addr   <= addr;
                        r_sdata  <= store_data;
`ifdef NEXUS_MEM_TIMEOUT_EN
                        tmo_cnt  <= '0;
`endif
                        if (access_fault(is_store, funct3, addr[1:0])) begin
                            state     <= ERR;
                            out_valid <= 1'b1;
                            mem_err   <= 1'b1;
                            load_data <= '0;
                        end else begin
                            state <= REQ;
                        end
                    end
                end
                REQ: begin
`ifdef NEXUS_MEM_TIMEOUT_EN
                    tmo_cnt <= tmo_cnt + 16'd1;
`endif
                    if (dmem.gnt) begin
                        state <= WAIT;
                    end
`ifdef NEXUS_MEM_TIMEOUT_EN
                    else if (tmo_hit) begin
                        state     <= IDLE;
                        out_valid <= 1'b1;
                        mem_err   <= 1'b1;
                        load_data <= '0;
                    end
`endif
                end
                WAIT: begin
`ifdef NEXUS_MEM_TIMEOUT_EN
                    tmo_cnt <= tmo_cnt + 16'd1;
`endif
                    if (dmem.rvalid) begin
                        state     <= IDLE;
                        out_valid <= 1'b1;
                        load_data <= r_store ? '0 : align_data;
                    end
`ifdef NEXUS_MEM_TIMEOUT_EN
                    else if (tmo_hit) begin
                        state     <= DRAIN;
                        out_valid <= 1'b1;
                        mem_err   <= 1'b1;
                        load_data <= '0;
                    end
`endif
                end
`ifdef NEXUS_MEM_TIMEOUT_EN
                DRAIN: begin
                    // The abandoned response is swallowed without a completion.
                    if (dmem.rvalid) begin
                        state <= IDLE;
                    end
                end
`endif
                ERR: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - self-checking bench for mem_access_stage
module tb_mem_access_stage;
    import nexus_mem_pkg::*;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] store_data = '0;
    logic        out_valid;
    logic [31:0] load_data;
    logic        mem_err;

    int n_vec = 0;
    int n_err = 0;

    mem_access_stage_if dmem ();

    mem_access_stage #(.WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .dmem       (dmem),
        .out_valid  (out_valid),
        .load_data  (load_data),
        .mem_err    (mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] rd;
        int          gdly;
        int          rdly;
        bit          noise;
        bit          err;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] ld;
    } vec_t;

    vec_t tbl[15];

    task automatic check(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s %s: got %h expected %h", tag, what, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain arithmetic over access size and byte offset.
    function automatic bit model_err(input bit st, input logic [2:0] f3, input logic [31:0] a);
        int sz;
        sz = 1 << f3[1:0];
        if (f3[1:0] == 2'd3) return 1'b1;
        if (st && f3[2]) return 1'b1;
        if (!st && f3 == 3'd6) return 1'b1;
        return (a % sz) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        int sz;
        sz = 1 << f3[1:0];
        return 4'(((1 << sz) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] model_wdata(input bit st, input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        int sz;
        sz = 1 << f3[1:0];
        w = '0;
        if (st) begin
            for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % sz) +: 8];
        end
        return w;
    endfunction

    function automatic logic [31:0] model_load(input bit st, input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rd);
        logic [31:0] v;
        logic [31:0] mask;
        int sz;
        if (st) return 32'h0;
        sz = 1 << f3[1:0];
        v = rd >> (8 * (a % 4));
        if (sz < 4) begin
            mask = (32'h1 << (8 * sz)) - 32'h1;
            v = v & mask;
            if (!f3[2] && v[8*sz-1]) v = v | ~mask;
        end
        return v;
    endfunction

    task automatic run_access(input string tag, input vec_t v);
        int waited;
        waited = 0;
        while (!in_ready && waited < 20) begin
            step();
            waited++;
        end
        check(tag, "in_ready_before_accept", {31'b0, in_ready}, 32'h1);
        in_valid = 1'b1;
        is_store = v.st;
        funct3 = v.f3;
        addr = v.a;
        store_data = v.d;
        step();
        in_valid = 1'b0;
        addr = $urandom;
        store_data = $urandom;
        if (v.err) begin
            check(tag, "err_out_valid", {31'b0, out_valid}, 32'h1);
            check(tag, "err_mem_err", {31'b0, mem_err}, 32'h1);
            check(tag, "err_load_data", load_data, 32'h0);
            check(tag, "err_no_req", {31'b0, dmem.req}, 32'h0);
            step();
            check(tag, "err_single_pulse", {31'b0, out_valid}, 32'h0);
        end else begin
            for (int i = 0; i <= v.gdly; i++) begin
                check(tag, "req", {31'b0, dmem.req}, 32'h1);
                check(tag, "we", {31'b0, dmem.we}, {31'b0, v.st});
                check(tag, "dmem_addr", dmem.addr, {v.a[31:2], 2'b00});
                check(tag, "be", {28'b0, dmem.be}, {28'b0, v.be});
                check(tag, "wdata", dmem.wdata, v.wd);
                check(tag, "in_ready_busy", {31'b0, in_ready}, 32'h0);
                dmem.gnt = (i == v.gdly);
                dmem.rvalid = v.noise && (i == v.gdly);
                dmem.rdata = ~v.rd;
                step();
            end
            dmem.gnt = 1'b0;
            dmem.rvalid = 1'b0;
            for (int i = 0; i < v.rdly; i++) begin
                check(tag, "wait_req_low", {31'b0, dmem.req}, 32'h0);
                check(tag, "wait_no_done", {31'b0, out_valid}, 32'h0);
                step();
            end
            check(tag, "wait_no_done", {31'b0, out_valid}, 32'h0);
            dmem.rvalid = 1'b1;
            dmem.rdata = v.rd;
            step();
            dmem.rvalid = 1'b0;
            dmem.rdata = $urandom;
            check(tag, "done_out_valid", {31'b0, out_valid}, 32'h1);
            check(tag, "done_mem_err", {31'b0, mem_err}, 32'h0);
            check(tag, "done_load_data", load_data, v.ld);
            check(tag, "done_in_ready", {31'b0, in_ready}, 32'h1);
        end
    endtask

    initial begin
        vec_t rv;
        int k;

        dmem.gnt = 1'b0;
        dmem.rvalid = 1'b0;
        dmem.rdata = '0;

        tbl[0]  = '{1'b1, SW,     32'h1000, 32'hDEADBEEF, 32'h0,        0, 0, 1'b0, 1'b0, 4'b1111, 32'hDEADBEEF, 32'h0};
        tbl[1]  = '{1'b1, SB,     32'h1003, 32'h000000A5, 32'h0,        1, 1, 1'b0, 1'b0, 4'b1000, 32'hA5A5A5A5, 32'h0};
        tbl[2]  = '{1'b0, LB,     32'h2002, 32'h0,        32'h00800000, 0, 0, 1'b1, 1'b0, 4'b0100, 32'h0,        32'hFFFFFF80};
        tbl[3]  = '{1'b0, LBU,    32'h2002, 32'h0,        32'h00800000, 0, 0, 1'b0, 1'b0, 4'b0100, 32'h0,        32'h00000080};
        tbl[4]  = '{1'b0, LW,     32'h2002, 32'h0,        32'h0,        0, 0, 1'b0, 1'b1, 4'b0000, 32'h0,        32'h0};
        tbl[5]  = '{1'b0, LW,     32'h3000, 32'h0,        32'h12345678, 5, 0, 1'b0, 1'b0, 4'b1111, 32'h0,        32'h12345678};
        tbl[6]  = '{1'b1, SH,     32'h1002, 32'hCAFE1234, 32'h0,        0, 2, 1'b0, 1'b0, 4'b1100, 32'h12341234, 32'h0};
        tbl[7]  = '{1'b0, LH,     32'h4002, 32'h0,        32'h80010000, 0, 0, 1'b0, 1'b0, 4'b1100, 32'h0,        32'hFFFF8001};
        tbl[8]  = '{1'b0, LHU,    32'h4002, 32'h0,        32'h80010000, 1, 0, 1'b0, 1'b0, 4'b1100, 32'h0,        32'h00008001};
        tbl[9]  = '{1'b0, LH,     32'h4001, 32'h0,        32'h0,        0, 0, 1'b0, 1'b1, 4'b0000, 32'h0,        32'h0};
        tbl[10] = '{1'b1, 3'b011, 32'h5000, 32'h0,        32'h0,        0, 0, 1'b0, 1'b1, 4'b0000, 32'h0,        32'h0};
        tbl[11] = '{1'b0, 3'b110, 32'h5000, 32'h0,        32'h0,        0, 0, 1'b0, 1'b1, 4'b0000, 32'h0,        32'h0};
        tbl[12] = '{1'b0, LB,     32'h5001, 32'h0,        32'h00007F00, 0, 0, 1'b0, 1'b0, 4'b0010, 32'h0,        32'h0000007F};
        tbl[13] = '{1'b1, SH,     32'h1001, 32'h0,        32'h0,        0, 0, 1'b0, 1'b1, 4'b0000, 32'h0,        32'h0};
        tbl[14] = '{1'b0, LW,     32'h6004, 32'h0,        32'h89ABCDEF, 0, 3, 1'b1, 1'b0, 4'b1111, 32'h0,        32'h89ABCDEF};

        // Reset values
        step();
        check("reset", "in_ready", {31'b0, in_ready}, 32'h1);
        check("reset", "req", {31'b0, dmem.req}, 32'h0);
        check("reset", "we", {31'b0, dmem.we}, 32'h0);
        check("reset", "dmem_addr", dmem.addr, 32'h0);
        check("reset", "be", {28'b0, dmem.be}, 32'h0);
        check("reset", "wdata", dmem.wdata, 32'h0);
        check("reset", "out_valid", {31'b0, out_valid}, 32'h0);
        check("reset", "load_data", load_data, 32'h0);
        check("reset", "mem_err", {31'b0, mem_err}, 32'h0);
        rst_n = 1'b1;
        step();

        // Directed table, back to back
        for (int i = 0; i < 15; i++) run_access($sformatf("vec%0d", i), tbl[i]);
        step();

        // Randomized accesses against the reference model
        for (int i = 0; i < 60; i++) begin
            rv.st = 1'($urandom_range(0, 1));
            rv.f3 = 3'($urandom_range(0, 7));
            rv.a = $urandom;
            if ($urandom_range(0, 2) != 0) begin
                if (rv.f3[1:0] == 2'd2) rv.a[1:0] = 2'd0;
                else if (rv.f3[1:0] == 2'd1) rv.a[0] = 1'b0;
            end
            rv.d = $urandom;
            rv.rd = $urandom;
            rv.gdly = $urandom_range(0, 2);
            rv.rdly = $urandom_range(0, 2);
            rv.noise = 1'($urandom_range(0, 1));
            rv.err = model_err(rv.st, rv.f3, rv.a);
            rv.be = rv.err ? 4'b0 : model_be(rv.f3, rv.a);
            rv.wd = rv.err ? 32'h0 : model_wdata(rv.st, rv.f3, rv.d);
            rv.ld = rv.err ? 32'h0 : model_load(rv.st, rv.f3, rv.a, rv.rd);
            run_access($sformatf("rnd%0d", i), rv);
        end
        step();

        // Reset while a request is outstanding drops dmem_req without a clock edge
        in_valid = 1'b1; is_store = 1'b1; funct3 = SW; addr = 32'h1000; store_data = 32'h11223344;
        step();
        in_valid = 1'b0;
        check("rst_req", "req_before", {31'b0, dmem.req}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_req", "req_async_drop", {31'b0, dmem.req}, 32'h0);
        check("rst_req", "in_ready_async", {31'b0, in_ready}, 32'h1);
        step();
        rst_n = 1'b1;
        step();
        check("rst_req", "no_completion", {31'b0, out_valid}, 32'h0);

        // Reset while waiting for the response discards it
        in_valid = 1'b1; is_store = 1'b0; funct3 = LW; addr = 32'h3000;
        step();
        in_valid = 1'b0;
        dmem.gnt = 1'b1;
        step();
        dmem.gnt = 1'b0;
        check("rst_wait", "busy", {31'b0, in_ready}, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_wait", "idle_async", {31'b0, in_ready}, 32'h1);
        check("rst_wait", "req_low", {31'b0, dmem.req}, 32'h0);
        step();
        rst_n = 1'b1;
        dmem.rvalid = 1'b1;
        dmem.rdata = 32'hCAFEF00D;
        step();
        dmem.rvalid = 1'b0;
        check("rst_wait", "stale_rvalid_ignored", {31'b0, out_valid}, 32'h0);
        step();
        check("rst_wait", "stale_rvalid_ignored2", {31'b0, out_valid}, 32'h0);
        run_access("post_rst", tbl[7]);
        step();

`ifdef NEXUS_MEM_TIMEOUT_EN
        // Grant never arrives: abort after TMO cycles in REQ
        in_valid = 1'b1; is_store = 1'b0; funct3 = LW; addr = 32'h7000;
        step();
        in_valid = 1'b0;
        k = 1;
        while (!out_valid && k < 30) begin
            check("tmo_req", "req_held", {31'b0, dmem.req}, 32'h1);
            step();
            k++;
        end
        check("tmo_req", "latency", k, TMO + 1);
        check("tmo_req", "mem_err", {31'b0, mem_err}, 32'h1);
        check("tmo_req", "load_data", load_data, 32'h0);
        check("tmo_req", "req_dropped", {31'b0, dmem.req}, 32'h0);
        check("tmo_req", "idle", {31'b0, in_ready}, 32'h1);
        step();

        // Response never arrives: error pulse, then drain the late response silently
        in_valid = 1'b1; is_store = 1'b0; funct3 = LW; addr = 32'h7100;
        step();
        in_valid = 1'b0;
        dmem.gnt = 1'b1;
        step();
        dmem.gnt = 1'b0;
        k = 2;
        while (!out_valid && k < 30) begin
            step();
            k++;
        end
        check("tmo_wait", "latency", k, TMO + 1);
        check("tmo_wait", "mem_err", {31'b0, mem_err}, 32'h1);
        check("tmo_wait", "drain_not_ready", {31'b0, in_ready}, 32'h0);
        step();
        check("tmo_wait", "single_pulse", {31'b0, out_valid}, 32'h0);
        check("tmo_wait", "drain_hold", {31'b0, in_ready}, 32'h0);
        dmem.rvalid = 1'b1;
        dmem.rdata = 32'h55555555;
        step();
        dmem.rvalid = 1'b0;
        check("tmo_wait", "late_rvalid_no_pulse", {31'b0, out_valid}, 32'h0);
        check("tmo_wait", "back_to_idle", {31'b0, in_ready}, 32'h1);
        run_access("post_tmo", tbl[0]);
        step();
`else
        k = 0;
        // Without the timeout a withheld grant keeps the request up
        in_valid = 1'b1; is_store = 1'b0; funct3 = LW; addr = 32'h7000;
        step();
        in_valid = 1'b0;
        while (k < 20) begin
            step();
            k++;
        end
        check("no_tmo", "req_still_held", {31'b0, dmem.req}, 32'h1);
        check("no_tmo", "no_error", {31'b0, out_valid}, 32'h0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

endmodule
